instr_register_reader: RTL and testbench



---
 rtl/instr_register_reader.sv | 117 +++++++++++
 tb/tb_instr_register_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_reader.sv
// instr_register_reader: walks an address range of the instruction register, recomputes each result and streams it over valid/ready.
// Define INSTR_REGISTER_READER_CHECK_EN to add mismatch/mismatch_cnt checking against the stored res field.
module instr_register_reader #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           start_addr,
  input  logic [ADDR_W:0]             count,
  output logic                        busy,
  output logic [ADDR_W-1:0]           read_pointer,
  input  logic [4+2*OP_W+RES_W-1:0]   instruction_word,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ADDR_W-1:0]           res_addr,
  output logic [3:0]                  res_opc,
  output logic [RES_W-1:0]            res_data,
  output logic                        done
`ifdef INSTR_REGISTER_READER_CHECK_EN
  ,
  output logic                        mismatch,
  output logic [ADDR_W:0]             mismatch_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, EXEC, OUT, DONE} state_t;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opc_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] remaining;
  logic [1:0] wcnt;
  logic [3:0] opc_q;
  logic [OP_W-1:0] a_q, b_q;
  logic [RES_W-1:0] r_q;
  logic signed [RES_W-1:0] a_x, b_x, calc;
  logic hs;
  assign hs = state == OUT && res_ready;
  assign busy = state != IDLE;
  assign res_valid = state == OUT;
  assign done = state == DONE;
  // ptr stays put from ADDR until the handshake, so it doubles as the register address
  assign read_pointer = ptr;
  assign a_x = {{(RES_W-OP_W){a_q[OP_W-1]}}, a_q};
  assign b_x = {{(RES_W-OP_W){b_q[OP_W-1]}}, b_q};
  always_comb begin
    calc = '0;
    case (opc_t'(opc_q))
      PASSA: calc = a_x;
      PASSB: calc = b_x;
      ADD:   calc = a_x + b_x;
      SUB:   calc = a_x - b_x;
      MULT:  calc = a_x * b_x;
      DIV:   if (b_x != '0) calc = a_x / b_x;
      MOD:   if (b_x != '0) calc = a_x % b_x;
      default: calc = '0;
    endcase
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = count != '0 ? ADDR : DONE;
      ADDR: state_d = WAIT;
      WAIT: if (wcnt == '0) state_d = EXEC;
      EXEC: state_d = OUT;
      OUT:  if (res_ready) state_d = remaining == (ADDR_W+1)'(1) ? DONE : ADDR;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      wcnt      <= '0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      res_addr  <= '0;
      res_opc   <= '0;
      res_data  <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start && count != '0) begin
        ptr       <= start_addr;
        remaining <= count;
      end
      if (state == ADDR) wcnt <= 2'(RD_LAT - 1);
      if (state == WAIT) begin
        wcnt <= wcnt - 1'b1;
        if (wcnt == '0) {opc_q, a_q, b_q, r_q} <= instruction_word;
      end
      if (state == EXEC) begin
        res_addr <= ptr;
        res_opc  <= opc_q;
        res_data <= calc;
      end
      if (hs) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
`ifdef INSTR_REGISTER_READER_CHECK_EN
  assign mismatch = res_valid && r_q != res_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mismatch_cnt <= '0;
    else if (state == IDLE && start) mismatch_cnt <= '0;
    else if (hs && mismatch) mismatch_cnt <= mismatch_cnt + 1'b1;
`else
  logic unused_res;
  assign unused_res = ^r_q;
`endif
endmodule

// File: tb/tb_instr_register_reader.sv
// tb_instr_register_reader: table vectors, hand-written corner sequences and random ranges checked against a reference model.
module tb_instr_register_reader;
  localparam int RD_LAT = 1;
  typedef struct packed {logic [3:0] opc; logic [31:0] a; logic [31:0] b; logic [63:0] res;} ent_t;
  typedef struct {logic [3:0] opc; int a; int b; logic [63:0] exp;} vec_t;
  typedef struct {logic [4:0] addr; logic [3:0] opc; logic [63:0] data; logic mm;} beat_t;
  logic clk = 0, reset_n = 0, start = 0, res_ready = 1;
  logic [4:0] start_addr = '0, read_pointer, res_addr;
  logic [5:0] count = '0;
  logic busy, res_valid, done;
  logic [3:0] res_opc;
  logic [63:0] res_data;
  logic [131:0] instruction_word;
`ifdef INSTR_REGISTER_READER_CHECK_EN
  logic mismatch;
  logic [5:0] mismatch_cnt;
`endif
  ent_t mem [32];
  logic [4:0] rp_pipe [RD_LAT];
  beat_t beats[$];
  int hs_cyc[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0, cyc = 0, mode = 0;
  logic tog = 0, hold_v = 0, prev_done = 0;
  logic [73:0] hold_d;
  vec_t vt [14];

  instr_register_reader #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .read_pointer(read_pointer), .instruction_word(instruction_word),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_opc(res_opc),
    .res_data(res_data), .done(done)
`ifdef INSTR_REGISTER_READER_CHECK_EN
    , .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // register array with RD_LAT cycles of read latency
  always @(posedge clk) begin
    rp_pipe[0] <= read_pointer;
    for (int k = 1; k < RD_LAT; k++) rp_pipe[k] <= rp_pipe[k-1];
  end
  assign instruction_word = mem[rp_pipe[RD_LAT-1]];
  // mode 0: ready high, 1: toggling, 2: random, 3: held low
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    res_ready = mode == 0 ? 1'b1 : mode == 1 ? tog : mode == 2 ? 1'($urandom % 2) : 1'b0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint model(input logic [3:0] opc, input int a, input int b);
    longint x = a, y = b;
    case (opc)
      1: return x;
      2: return y;
      3: return x + y;
      4: return x - y;
      5: return x * y;
      6: return y == 0 ? 0 : x / y;
      7: return y == 0 ? 0 : x % y;
      default: return 0;
    endcase
  endfunction

  function automatic int rnd_op();
    case ($urandom % 4)
      0: return 0;
      1: return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin
      mem[i].opc = 4'($urandom % 16);
      mem[i].a = rnd_op();
      mem[i].b = rnd_op();
      mem[i].res = model(mem[i].opc, mem[i].a, mem[i].b);
    end
  endtask

  always @(negedge clk) begin
    beat_t bt;
    if (!reset_n) begin
      hold_v = 0;
      prev_done = 0;
    end else begin
      if (hold_v) check("hold_stable", {res_valid, res_addr, res_opc, res_data}, hold_d);
      if (prev_done) check("busy_fall", busy, 1'b0);
      if (res_valid && res_ready) begin
        bt.addr = res_addr;
        bt.opc = res_opc;
        bt.data = res_data;
`ifdef INSTR_REGISTER_READER_CHECK_EN
        bt.mm = mismatch;
`else
        bt.mm = 1'b0;
`endif
        beats.push_back(bt);
        hs_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      hold_v = res_valid && !res_ready;
      hold_d = {1'b1, res_addr, res_opc, res_data};
      prev_done = done;
    end
  end

  task automatic run_seq(input logic [4:0] sa, input logic [5:0] cnt, input int inject);
    int t = 0;
    logic [4:0] a;
    logic [63:0] e;
    beats.delete();
    hs_cyc.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1; start_addr = sa; count = cnt;
    @(posedge clk); #1;
    start = 0;
    if (inject > 0) begin
      repeat (inject) @(posedge clk);
      #1;
      start = 1; start_addr = 5'd20; count = 6'd2;
      @(posedge clk); #1;
      start = 0;
    end
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("timeout", t < 3000, 1'b1);
    repeat (2) @(negedge clk);
    check("beat_count", beats.size(), cnt);
    check("done_count", done_cnt, 1);
    foreach (beats[i]) if (i < cnt) begin
      a = sa + 5'(i);
      e = model(mem[a].opc, mem[a].a, mem[a].b);
      check("beat_addr", beats[i].addr, a);
      check("beat_opc", beats[i].opc, mem[a].opc);
      check("beat_data", beats[i].data, e);
`ifdef INSTR_REGISTER_READER_CHECK_EN
      check("beat_mismatch", beats[i].mm, mem[a].res != e);
`endif
    end
  endtask

  initial begin
    vt[0]  = '{4'd3, 5, 3, 8};
    vt[1]  = '{4'd4, -15, 4, -19};
    vt[2]  = '{4'd5, 7, -2, -14};
    vt[3]  = '{4'd6, -7, 2, -3};
    vt[4]  = '{4'd7, -7, 2, -1};
    vt[5]  = '{4'd6, 9, 0, 0};
    vt[6]  = '{4'd7, 9, 0, 0};
    vt[7]  = '{4'd12, 5, 6, 0};
    vt[8]  = '{4'd0, 4, 5, 0};
    vt[9]  = '{4'd1, -9, 3, -9};
    vt[10] = '{4'd2, 1, -6, -6};
    vt[11] = '{4'd7, 7, -2, 1};
    vt[12] = '{4'd5, 32'h7fffffff, 32'h7fffffff, 64'h3FFF_FFFF_0000_0001};
    vt[13] = '{4'd4, 32'h80000000, 1, 64'hFFFF_FFFF_7FFF_FFFF};
    fill_rand();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, read_pointer, res_valid, res_addr, res_opc, res_data, done}, '0);
    #2 reset_n = 1;
    // table vectors, ready high: fixed per-beat spacing
    foreach (vt[i]) mem[i] = {vt[i].opc, vt[i].a, vt[i].b, vt[i].exp};
    mode = 0;
    run_seq(5'd0, 6'd14, 0);
    foreach (beats[i]) if (i < 14) check("table_data", beats[i].data, vt[i].exp);
    for (int i = 1; i < hs_cyc.size(); i++) check("beat_spacing", hs_cyc[i] - hs_cyc[i-1], RD_LAT + 3);
    // wrap with toggling backpressure
    fill_rand();
    mode = 1;
    run_seq(5'd30, 6'd4, 0);
    // count of zero
    mode = 0;
    beats.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1; start_addr = 5'd9; count = 6'd0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("cnt0_done", done, 1'b1);
    @(negedge clk);
    check("cnt0_done_low", done, 1'b0);
    check("cnt0_busy", busy, 1'b0);
    check("cnt0_beats", beats.size(), 0);
    check("cnt0_done_count", done_cnt, 1);
    // start while busy is dropped
    run_seq(5'd0, 6'd5, 3);
    // full register
    run_seq(5'd7, 6'd32, 0);
    // reset while a beat is pending
    mode = 3;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1; start_addr = 5'd2; count = 6'd3;
    @(posedge clk); #1;
    start = 0;
    for (int t = 0; t < 50 && !res_valid; t++) @(negedge clk);
    check("rst_pending_valid", res_valid, 1'b1);
    #2 reset_n = 0;
    #1 check("rst_mid_outputs", {busy, read_pointer, res_valid, res_addr, res_opc, res_data, done}, '0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    mode = 0;
    repeat (8) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    run_seq(5'd5, 6'd3, 0);
    // random ranges with random backpressure
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      mode = 2;
      run_seq(5'($urandom % 32), 6'($urandom_range(1, 32)), 0);
    end
`ifdef INSTR_REGISTER_READER_CHECK_EN
    fill_rand();
    mem[4].res = mem[4].res + 1;
    mode = 0;
    run_seq(5'd0, 6'd10, 0);
    foreach (beats[i]) check("chk_mismatch_beat", beats[i].mm, i == 4);
    check("chk_mismatch_cnt", mismatch_cnt, 6'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
